stream_join: RTL

- Two-input to one-output AXI-stream join: the merging counterpart of the fork.
- Accepts one beat from each of streams a and b, possibly in different cycles, and emits one combined beat on c as {b_data, a_data}.
- Per-input one-entry holding buffers plus a registered output stage, so c_valid and c_data are flop outputs.
- Used wherever forked branches must be re-synchronised.

---
 rtl/stream_join.sv | 102 ++++++++++
 1 files changed

// File: rtl/stream_join.sv
// Two-input AXI-stream join: one beat from a and one from b become one {b, a} beat on c.
// Optional STREAM_JOIN_LAST_EN adds last-flag buffering, c_last and a sticky last_err.
module stream_join #(
  parameter int DATA_WD = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WD-1:0]     a_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [DATA_WD-1:0]     b_data,
  input  logic                   b_valid,
  output logic                   b_ready,
`ifdef STREAM_JOIN_LAST_EN
  input  logic                   a_last,
  input  logic                   b_last,
  output logic                   c_last,
  output logic                   last_err,
`endif
  output logic [2*DATA_WD-1:0]   c_data,
  output logic                   c_valid,
  input  logic                   c_ready
);

  logic [DATA_WD-1:0] a_buf;
  logic [DATA_WD-1:0] b_buf;
  logic               a_full;
  logic               b_full;
  logic               c_free;
  logic               do_join;
  logic               a_cap;
  logic               b_cap;

  // A full buffer reopens in the same cycle it is drained by a join, so
  // c_ready reaches a_ready/b_ready combinationally.
  assign c_free  = !c_valid || c_ready;
  assign do_join = a_full && b_full && c_free;
  assign a_ready = !a_full || do_join;
  assign b_ready = !b_full || do_join;
  assign a_cap   = a_valid && a_ready;
  assign b_cap   = b_valid && b_ready;

  // Input holding stage: each side buffers independently of the other.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full <= 1'b0;
      a_buf  <= '0;
    end else if (a_cap) begin
      a_full <= 1'b1;
      a_buf  <= a_data;
    end else if (do_join) begin
      a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_full <= 1'b0;
      b_buf  <= '0;
    end else if (b_cap) begin
      b_full <= 1'b1;
      b_buf  <= b_data;
    end else if (do_join) begin
      b_full <= 1'b0;
    end
  end

  // Output register stage: c_data is only loaded on a join, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_data  <= '0;
    end else if (do_join) begin
      c_valid <= 1'b1;
      c_data  <= {b_buf, a_buf};
    end else if (c_ready) begin
      c_valid <= 1'b0;
    end
  end

`ifdef STREAM_JOIN_LAST_EN
  logic a_last_buf;
  logic b_last_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_last_buf <= 1'b0;
      b_last_buf <= 1'b0;
      c_last     <= 1'b0;
      last_err   <= 1'b0;
    end else begin
      if (a_cap) a_last_buf <= a_last;
      if (b_cap) b_last_buf <= b_last;
      if (do_join) begin
        c_last <= a_last_buf && b_last_buf;
        if (a_last_buf != b_last_buf) last_err <= 1'b1;
      end
    end
  end
`endif

endmodule
